// File: rtl/train_seq_gen_pkg.sv
// Shared types and constants for the train sequence generator.
// Imported by the interface, the station stack and the top level.
package train_pkg;

  localparam int MAX_TRAINS = 10;
  localparam int TRAIN_W    = 4;
  localparam int OPS_W      = 20;
  localparam int OP_IDX_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    BUILD,
    SEND,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/train_seq_gen_if.sv
// Request/departure bundle between a requester (master) and train_seq_gen (slave).
// sent_cnt exists only when TRAIN_SEQ_CNT_EN is defined.
interface train_seq_gen_if;
  import train_pkg::*;

  logic               start;
  logic [TRAIN_W-1:0] n_trains;
  logic [OPS_W-1:0]   ops;
  logic               busy;
  logic               out_valid;
  logic [TRAIN_W-1:0] data;
  logic               done;
  logic               err;
`ifdef TRAIN_SEQ_CNT_EN
  logic [15:0]        sent_cnt;

  modport master (output start, n_trains, ops,
                  input  busy, out_valid, data, done, err, sent_cnt);
  modport slave  (input  start, n_trains, ops,
                  output busy, out_valid, data, done, err, sent_cnt);
`else
  modport master (output start, n_trains, ops,
                  input  busy, out_valid, data, done, err);
  modport slave  (input  start, n_trains, ops,
                  output busy, out_valid, data, done, err);
`endif

endinterface

// File: rtl/train_seq_gen_stack.sv
// train_stack: 10-deep, 4-bit LIFO modelling the station siding.
// Push on full and pop on empty are ignored; the caller treats them as errors.
module train_stack
  import train_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [TRAIN_W-1:0] din,
  output logic [TRAIN_W-1:0] top,
  output logic               empty,
  output logic               full
);

  logic [TRAIN_W-1:0] mem_q [MAX_TRAINS];
  logic [TRAIN_W-1:0] mem_d [MAX_TRAINS];
  logic [3:0]         sp_q;
  logic [3:0]         sp_d;

  assign empty = (sp_q == 4'd0);
  assign full  = (sp_q == 4'(MAX_TRAINS));
  assign top   = empty ? '0 : mem_q[sp_q - 4'd1];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clear) begin
      sp_d = 4'd0;
    end else if (push && !full) begin
      mem_d[sp_q] = din;
      sp_d        = sp_q + 4'd1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= 4'd0;
      for (int i = 0; i < MAX_TRAINS; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/train_seq_gen.sv
// Replays a push/pop operation string through a station stack, then streams the departure order.
// Define TRAIN_SEQ_CNT_EN to add the 16-bit completed-sequence counter sent_cnt.
module train_seq_gen
  import train_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  train_seq_gen_if.slave bus
);

  state_e                state_q, state_d;
  logic [TRAIN_W-1:0]    n_q, n_d;
  logic [OPS_W-1:0]      ops_q, ops_d;
  logic [OP_IDX_W-1:0]   op_idx_q, op_idx_d;
  logic [TRAIN_W-1:0]    arr_q, arr_d;
  logic [TRAIN_W-1:0]    dep_q [MAX_TRAINS];
  logic [TRAIN_W-1:0]    dep_d [MAX_TRAINS];
  logic [3:0]            dep_cnt_q, dep_cnt_d;
  logic [3:0]            send_idx_q, send_idx_d;

  logic                  stk_clear, stk_push, stk_pop;
  logic [TRAIN_W-1:0]    stk_top;
  logic                  stk_empty, stk_full;
  logic                  op_last;

  train_stack u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (stk_clear),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (arr_q),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign op_last = (op_idx_q == ({n_q, 1'b0} - 5'd1));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    ops_d      = ops_q;
    op_idx_d   = op_idx_q;
    arr_d      = arr_q;
    dep_d      = dep_q;
    dep_cnt_d  = dep_cnt_q;
    send_idx_d = send_idx_q;
    stk_clear  = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d        = bus.n_trains;
          ops_d      = bus.ops;
          op_idx_d   = '0;
          arr_d      = 4'd1;
          dep_cnt_d  = 4'd0;
          send_idx_d = 4'd0;
          stk_clear  = 1'b1;
          if (bus.n_trains == 4'd0 || bus.n_trains > 4'(MAX_TRAINS)) state_d = ERR;
          else                                                       state_d = BUILD;
        end
      end
      BUILD: begin
        op_idx_d = op_idx_q + 5'd1;
        if (ops_q[op_idx_q]) begin
          if (arr_q > n_q || stk_full) begin
            state_d = ERR;
          end else begin
            stk_push = 1'b1;
            arr_d    = arr_q + 4'd1;
          end
        end else begin
          if (stk_empty || dep_cnt_q == 4'(MAX_TRAINS)) begin
            state_d = ERR;
          end else begin
            stk_pop           = 1'b1;
            dep_d[dep_cnt_q]  = stk_top;
            dep_cnt_d         = dep_cnt_q + 4'd1;
          end
        end
        // All N pushed and all N popped means the siding ended empty
        if (state_d != ERR && op_last) begin
          if (dep_cnt_d == n_q && arr_d == n_q + 4'd1) state_d = SEND;
          else                                         state_d = ERR;
        end
      end
      SEND: begin
        send_idx_d = send_idx_q + 4'd1;
        if (send_idx_q == n_q - 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      ops_q      <= '0;
      op_idx_q   <= '0;
      arr_q      <= '0;
      dep_cnt_q  <= '0;
      send_idx_q <= '0;
      for (int i = 0; i < MAX_TRAINS; i++) dep_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ops_q      <= ops_d;
      op_idx_q   <= op_idx_d;
      arr_q      <= arr_d;
      dep_q      <= dep_d;
      dep_cnt_q  <= dep_cnt_d;
      send_idx_q <= send_idx_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.data      = (state_q == SEND) ? dep_q[send_idx_q] : '0;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == ERR);

`ifdef TRAIN_SEQ_CNT_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (state_q == DONE) sent_cnt_d = sent_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_cnt_q <= '0;
    else        sent_cnt_q <= sent_cnt_d;
  end

  assign bus.sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_train_seq_gen.sv
// Self-checking bench for train_seq_gen: expected departures are queued from a stack model
// when a request is driven and popped as beats appear.
module tb_train_seq_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  train_seq_gen_if bus ();

  train_seq_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and follows it to completion; sample k is the k-th falling edge after the start edge
  task automatic run_seq(input string name, input logic [3:0] n, input logic [19:0] ops, input bit hold_start);
    logic [3:0] exp_q[$];
    logic [3:0] stk[$];
    logic [3:0] exp_beat;
    int n_i = int'(n);
    int err_at = 0;
    int arr = 1;
    int end_k, first_beat, beats, done_at, done_cnt, err_seen, err_cnt;
    bit leak = 0;
    bit busy_ok = 1;
    first_beat = 0; beats = 0; done_at = 0; done_cnt = 0; err_seen = 0; err_cnt = 0;

    if (n_i == 0 || n_i > 10) begin
      err_at = 1;
    end else begin
      for (int k = 0; k < 2 * n_i; k++) begin
        if (ops[k]) begin
          if (arr > n_i) begin err_at = k + 2; break; end
          stk.push_back(4'(arr));
          arr++;
        end else begin
          if (stk.size() == 0) begin err_at = k + 2; break; end
          exp_q.push_back(stk.pop_back());
        end
      end
      if (err_at == 0 && (stk.size() != 0 || exp_q.size() != n_i)) err_at = 2 * n_i + 1;
    end
    if (err_at != 0) exp_q.delete();
    end_k = (err_at != 0) ? err_at : 3 * n_i + 1;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.n_trains = n;
    bus.ops      = ops;
    for (int k = 1; k <= end_k + 1; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        beats++;
        if (first_beat == 0) first_beat = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL %s_beat: unexpected beat at k=%0d data=%0d, required none", name, k, bus.data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (bus.data !== exp_beat) begin
            failures++;
            $display("[TB] FAIL %s_beat: k=%0d data=%0d, required %0d", name, k, bus.data, exp_beat);
          end
        end
      end else if (bus.data !== 4'd0) begin
        leak = 1'b1;
      end
      if (bus.done === 1'b1) begin done_cnt++; if (done_at == 0) done_at = k; end
      if (bus.err === 1'b1) begin err_cnt++; if (err_seen == 0) err_seen = k; end
      if (bus.busy !== (k <= end_k)) busy_ok = 1'b0;
      if (!hold_start || k >= 2 * n_i) bus.start = 1'b0;
      bus.n_trains = 4'($urandom_range(0, 15));
      bus.ops      = 20'($urandom);
    end
    bus.start = 1'b0;

    checks++;
    if (err_at != 0) begin
      if (err_seen != err_at || err_cnt != 1) begin
        failures++;
        $display("[TB] FAIL %s_err: err at k=%0d x%0d, required k=%0d x1", name, err_seen, err_cnt, err_at);
      end
    end else if (err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL %s_err: err pulsed %0d times, required 0", name, err_cnt);
    end
    checks++;
    if (err_at != 0) begin
      if (beats != 0 || done_cnt != 0) begin
        failures++;
        $display("[TB] FAIL %s_nobeats: beats=%0d done=%0d, required 0 and 0", name, beats, done_cnt);
      end
    end else if (first_beat != 2 * n_i + 1 || beats != n_i || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_beats: first=%0d count=%0d, required first=%0d count=%0d", name, first_beat, beats, 2 * n_i + 1, n_i);
    end
    if (err_at == 0) begin
      checks++;
      if (done_at != 3 * n_i + 1 || done_cnt != 1) begin
        failures++;
        $display("[TB] FAIL %s_done: done at k=%0d x%0d, required k=%0d x1", name, done_at, done_cnt, 3 * n_i + 1);
      end
    end
    checks++;
    if (!busy_ok || leak) begin
      failures++;
      $display("[TB] FAIL %s_busy_data: busy_ok=%0d data_leak=%0d, required 1 and 0", name, busy_ok, leak);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.n_trains = 4'd0;
    bus.ops      = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: %b, required 0", bus.busy); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: %b, required 0", bus.out_valid); end
    checks++;
    if (bus.data !== 4'd0) begin failures++; $display("[TB] FAIL reset_data: %0d, required 0", bus.data); end
    checks++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulses: done=%b err=%b, required 0 0", bus.done, bus.err);
    end
`ifdef TRAIN_SEQ_CNT_EN
    checks++;
    if (bus.sent_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_sent_cnt: %0d, required 0", bus.sent_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_orders();
    run_seq("asc3", 4'd3, 20'h00015, 1'b0);
    run_seq("rev3", 4'd3, 20'h00007, 1'b0);
    run_seq("one",  4'd1, 20'h00001, 1'b0);
  endtask

  task automatic test_errors();
`ifdef TRAIN_SEQ_CNT_EN
    logic [15:0] cnt0;
    cnt0 = bus.sent_cnt;
`endif
    run_seq("pop_first",   4'd2,  20'h00000, 1'b0);
    run_seq("n_zero",      4'd0,  20'h00015, 1'b0);
    run_seq("n_eleven",    4'd11, 20'h003FF, 1'b0);
    run_seq("push_over",   4'd2,  20'h00007, 1'b0);
    run_seq("late_push",   4'd2,  20'h0000B, 1'b0);
`ifdef TRAIN_SEQ_CNT_EN
    checks++;
    if (bus.sent_cnt !== cnt0) begin
      failures++;
      $display("[TB] FAIL err_sent_cnt: %0d, required %0d", bus.sent_cnt, cnt0);
    end
`endif
  endtask

  task automatic test_max();
`ifdef TRAIN_SEQ_CNT_EN
    logic [15:0] cnt0;
    cnt0 = bus.sent_cnt;
`endif
    run_seq("max10", 4'd10, 20'h003FF, 1'b0);
`ifdef TRAIN_SEQ_CNT_EN
    checks++;
    if (bus.sent_cnt !== cnt0 + 16'd1) begin
      failures++;
      $display("[TB] FAIL max_sent_cnt: %0d, required %0d", bus.sent_cnt, cnt0 + 16'd1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [19:0] ops;
    logic [3:0]  n;
    int pushes, depth;
    for (int r = 0; r < 5; r++) begin
      n = 4'($urandom_range(1, 10));
      pushes = 0;
      depth  = 0;
      ops    = '0;
      for (int k = 0; k < 2 * int'(n); k++) begin
        if (pushes < int'(n) && (depth == 0 || $urandom_range(0, 1) == 1)) begin
          ops[k] = 1'b1; pushes++; depth++;
        end else begin
          ops[k] = 1'b0; depth--;
        end
      end
      run_seq($sformatf("rand%0d", r), n, ops, r == 1);
    end
  endtask

  task automatic test_reset_mid_send();
    int bad = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.n_trains = 4'd4;
    bus.ops      = 20'h00033;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data !== 4'd1) begin
      failures++;
      $display("[TB] FAIL mid_second_beat: valid=%b data=%0d, required 1 and 1", bus.out_valid, bus.data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.out_valid, bus.data, bus.done, bus.err} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: busy=%b valid=%b data=%0d done=%b err=%b, required all 0",
               bus.busy, bus.out_valid, bus.data, bus.done, bus.err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.done || bus.err || bus.busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL mid_reset_quiet: %0d active cycles after reset, required 0", bad);
    end
    run_seq("after_reset", 4'd4, 20'h00033, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_orders();
    test_errors();
    test_max();
    test_back_to_back();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
